// File: rtl/word_serializer_pkg.sv
// Shared types for the word serializer: lane count, lane index and FSM state.
package word_serializer_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] lane_index_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/word_serializer_hold.sv
// Single-entry holding register in front of the shifter. It is filled by
// the input handshake and emptied when the FSM moves the word into the shifter.
module word_hold_buffer
    import word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                                       sender_clock,
    input  logic                                       sender_reset_n,
    input  logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0]  word_in,
    input  logic                                       capture,
    input  logic                                       load,
    output logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0]  hold_word,
    output logic                                       hold_valid
);

    // capture and load are never both high: capture needs an empty buffer, load a full one.
    always_ff @(posedge sender_clock) begin
        if (!sender_reset_n) begin
            hold_valid <= 1'b0;
            hold_word  <= '0;
        end else if (capture) begin
            hold_valid <= 1'b1;
            hold_word  <= word_in;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Splits 4-lane words into DATA_WIDTH beats (lane 0 first) for the async fifo.
// Optional words_sent counter is built in when WORD_SERIALIZER_COUNT_EN is defined.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | shifter empty; waiting for the hold buffer to fill
//   SHIFT | emitting shift_word[lane_index], one beat per unstalled cycle
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int POINTER_WIDTH   = 8,
    parameter int FIFO_HIGH_WATER = (2**POINTER_WIDTH) - 4
) (
    input  logic                                       sender_clock,
    input  logic                                       sender_reset_n,
    input  logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0]  word_in,
    input  logic                                       word_in_valid,
    output logic                                       word_in_ready,
    input  logic [POINTER_WIDTH-1:0]                   fifo_used,
    output logic                                       data_out_enable,
    output logic [DATA_WIDTH-1:0]                      data_out,
    output logic                                       busy
`ifdef WORD_SERIALIZER_COUNT_EN
    ,
    output logic [31:0]                                words_sent
`endif
);

    localparam logic [POINTER_WIDTH-1:0] HIGH_WATER = FIFO_HIGH_WATER[POINTER_WIDTH-1:0];

    state_t                                     state;
    state_t                                     state_next;
    lane_index_t                                lane_index;
    lane_index_t                                lane_next;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0]  shift_word;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0]  hold_word;
    logic                                       hold_valid;
    logic                                       capture;
    logic                                       load_shift;
    logic                                       beat_fire;
    logic                                       stall;

    assign stall   = (fifo_used >= HIGH_WATER);
    assign capture = word_in_valid && word_in_ready;

    word_hold_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .sender_clock   (sender_clock),
        .sender_reset_n (sender_reset_n),
        .word_in        (word_in),
        .capture        (capture),
        .load           (load_shift),
        .hold_word      (hold_word),
        .hold_valid     (hold_valid)
    );

    always_ff @(posedge sender_clock) begin
        if (!sender_reset_n) begin
            state           <= IDLE;
            lane_index      <= '0;
            shift_word      <= '0;
            data_out        <= '0;
            data_out_enable <= 1'b0;
        end else begin
            state           <= state_next;
            lane_index      <= lane_next;
            data_out_enable <= beat_fire;
            if (beat_fire) begin
                data_out <= shift_word[lane_index];
            end
            if (load_shift) begin
                shift_word <= hold_word;
            end
        end
    end

    // A stall on the lane-3 cycle defers the reload along with the beat.
    always_comb begin
        state_next = state;
        load_shift = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    state_next = SHIFT;
                    load_shift = 1'b1;
                end
            end
            SHIFT: begin
                if (!stall && lane_index == 2'd3) begin
                    if (hold_valid) begin
                        load_shift = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // lane_index only returns to 0 through a load; it parks at 3 when going idle.
    always_comb begin
        beat_fire     = (state == SHIFT) && !stall;
        busy          = hold_valid || (state == SHIFT);
        word_in_ready = sender_reset_n && !hold_valid;
        lane_next     = lane_index;
        if (load_shift) begin
            lane_next = '0;
        end else if (beat_fire && lane_index != 2'd3) begin
            lane_next = lane_index + 2'd1;
        end
    end

`ifdef WORD_SERIALIZER_COUNT_EN
    always_ff @(posedge sender_clock) begin
        if (!sender_reset_n) begin
            words_sent <= '0;
        end else if (beat_fire && lane_index == 2'd3) begin
            words_sent <= words_sent + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer: directed timing scenarios plus a
// randomized run checked against a beat-queue reference model.
module tb_word_serializer;

    localparam int DW = 8;
    localparam int PW = 8;
    localparam int HW = 252;

    logic               sender_clock   = 1'b0;
    logic               sender_reset_n = 1'b0;
    logic [3:0][DW-1:0] word_in        = '0;
    logic               word_in_valid  = 1'b0;
    logic               word_in_ready;
    logic [PW-1:0]      fifo_used      = '0;
    logic               data_out_enable;
    logic [DW-1:0]      data_out;
    logic               busy;
`ifdef WORD_SERIALIZER_COUNT_EN
    logic [31:0]        words_sent;
`endif

    word_serializer #(
        .DATA_WIDTH    (DW),
        .POINTER_WIDTH (PW)
    ) dut (
        .sender_clock    (sender_clock),
        .sender_reset_n  (sender_reset_n),
        .word_in         (word_in),
        .word_in_valid   (word_in_valid),
        .word_in_ready   (word_in_ready),
        .fifo_used       (fifo_used),
        .data_out_enable (data_out_enable),
        .data_out        (data_out),
        .busy            (busy)
`ifdef WORD_SERIALIZER_COUNT_EN
        ,
        .words_sent      (words_sent)
`endif
    );

    always #5 sender_clock = ~sender_clock;

    int            chk_cnt = 0;
    int            err_cnt = 0;
    logic [DW-1:0] exp_q[$];
    bit            last_acc;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: model the handshake and the beat stream, then sample #1 after the edge.
    task automatic tick();
        bit                 acc;
        bit                 rst;
        logic [PW-1:0]      fu;
        logic [3:0][DW-1:0] w;
        acc = word_in_valid && word_in_ready && sender_reset_n;
        rst = !sender_reset_n;
        fu  = fifo_used;
        w   = word_in;
        @(posedge sender_clock);
        #1;
        last_acc = acc;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (acc) begin
                for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
            end
            if (int'(fu) >= HW) check_eq("stall_enable", 32'(data_out_enable), 0);
        end
        if (data_out_enable) begin
            if (exp_q.size() == 0) check_eq("spurious_beat", 32'(data_out_enable), 0);
            else                   check_eq("beat_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
    endtask

    logic [3:0][DW-1:0] w4;
    logic [3:0][DW-1:0] wb;
    int                 sent, beats, first, last;
`ifdef WORD_SERIALIZER_COUNT_EN
    logic [31:0]        cnt_base;
`endif

    initial begin
        // reset state
        repeat (3) tick();
        check_eq("rst_enable", 32'(data_out_enable), 0);
        check_eq("rst_data", 32'(data_out), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ready", 32'(word_in_ready), 0);
`ifdef WORD_SERIALIZER_COUNT_EN
        check_eq("rst_words_sent", words_sent, 0);
`endif
        sender_reset_n = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'(word_in_ready), 1);
        tick();

        // single word, latency and lane order
        word_in       = 32'h44332211;
        word_in_valid = 1'b1;
        check_eq("s1_ready_idle", 32'(word_in_ready), 1);
        tick();
        word_in_valid = 1'b0;
        check_eq("s1_ready_drop", 32'(word_in_ready), 0);
        check_eq("s1_busy", 32'(busy), 1);
        tick();
        check_eq("s1_t1_enable", 32'(data_out_enable), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("s1_enable", 32'(data_out_enable), 1);
            check_eq("s1_data", 32'(data_out), 32'(8'h11 * (i + 1)));
        end
        check_eq("s1_busy_end", 32'(busy), 0);
        tick();
        check_eq("s1_enable_end", 32'(data_out_enable), 0);

        // three back-to-back words
`ifdef WORD_SERIALIZER_COUNT_EN
        cnt_base = words_sent;
`endif
        sent = 0; beats = 0; first = -1; last = -1;
        word_in       = $urandom;
        word_in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (last_acc) begin
                sent++;
                if (sent == 3) word_in_valid = 1'b0;
                else           word_in = $urandom;
            end
            if (data_out_enable) begin
                beats++;
                if (first < 0) first = c;
                last = c;
            end
        end
        check_eq("b2b_accepts", 32'(sent), 3);
        check_eq("b2b_beats", 32'(beats), 12);
        check_eq("b2b_span", 32'(last - first), 11);
        check_eq("b2b_drained", 32'(exp_q.size()), 0);
`ifdef WORD_SERIALIZER_COUNT_EN
        check_eq("b2b_words_sent", words_sent - cnt_base, 3);
`endif

        // stall for 5 cycles after lane 1
        w4            = $urandom;
        word_in       = w4;
        word_in_valid = 1'b1;
        tick();
        word_in_valid = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("st_pre_data", 32'(data_out), 32'(w4[i]));
        end
        fifo_used = 8'd252;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("st_hold_enable", 32'(data_out_enable), 0);
            check_eq("st_hold_busy", 32'(busy), 1);
        end
        fifo_used = 8'd0;
        for (int i = 2; i < 4; i++) begin
            tick();
            check_eq("st_resume_enable", 32'(data_out_enable), 1);
            check_eq("st_resume_data", 32'(data_out), 32'(w4[i]));
        end
        tick();
        check_eq("st_end_enable", 32'(data_out_enable), 0);

        // reset after lane 1 of word A, then word B in full
        word_in       = $urandom;
        word_in_valid = 1'b1;
        tick();
        word_in_valid = 1'b0;
        tick();
        tick();
        tick();
        sender_reset_n = 1'b0;
        wb             = $urandom;
        word_in        = wb;
        word_in_valid  = 1'b1;
        #1;
        check_eq("mr_ready_in_reset", 32'(word_in_ready), 0);
        tick();
        check_eq("mr_enable", 32'(data_out_enable), 0);
        check_eq("mr_busy", 32'(busy), 0);
`ifdef WORD_SERIALIZER_COUNT_EN
        check_eq("mr_words_sent", words_sent, 0);
`endif
        sender_reset_n = 1'b1;
        word_in_valid  = 1'b0;
        #1;
        check_eq("mr_ready_after", 32'(word_in_ready), 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("mr_quiet", 32'(data_out_enable), 0);
        end
        word_in_valid = 1'b1;
        tick();
        word_in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("mr_b_enable", 32'(data_out_enable), 1);
            check_eq("mr_b_data", 32'(data_out), 32'(wb[i]));
        end

        // boundary: 251 never stalls
        fifo_used     = 8'd251;
        word_in       = $urandom;
        word_in_valid = 1'b1;
        tick();
        word_in_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("bd_251_enable", 32'(data_out_enable), 1);
        end

        // boundary: alternating 252/251, beats only after 251 edges
        for (int i = 0; i < 11; i++) begin
            fifo_used     = (i % 2 == 0) ? 8'd252 : 8'd251;
            word_in_valid = (i == 0);
            if (i == 0) word_in = $urandom;
            tick();
            check_eq("bd_toggle_enable", 32'(data_out_enable),
                     32'(i == 3 || i == 5 || i == 7 || i == 9));
        end

        // randomized traffic against the beat queue
        for (int c = 0; c < 400; c++) begin
            int r;
            r             = $urandom_range(0, 9);
            word_in_valid = 1'($urandom_range(0, 1));
            word_in       = $urandom;
            if (r < 6)      fifo_used = 8'($urandom_range(0, 250));
            else if (r < 8) fifo_used = 8'd251;
            else            fifo_used = 8'($urandom_range(252, 255));
            tick();
        end
        word_in_valid = 1'b0;
        fifo_used     = 8'd0;
        for (int c = 0; c < 40; c++) begin
            if (exp_q.size() == 0 && !busy) break;
            tick();
        end
        tick();
        check_eq("rand_drained", 32'(exp_q.size()), 0);
        check_eq("rand_busy_end", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
